tone_fm_seq_tx: RTL and testbench
=================================

TONE_FM_SEQ_TX -- requirements
Module: tone_fm_seq_tx

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
  IDX_W  4  melody index width; RAM depth 2**IDX_W
  AUD_W  16  audio increment width
  ACC_W  32  phase accumulator width, audio and carrier
  TICKS_PER_STEP  6_250_000  clocks per duration step
  CARRIER_INC  32'h0CCC_CCCD  carrier phase increment
  DEV_INC  32'h0000_4000  FM deviation increment
REQ-002 Ports SHALL be, as name, direction, width, meaning:
  clk  in  1  single clock
  rst_n  in  1  asynchronous active-low reset
  enable  in  1  play request, level
  loop  in  1  restart at end of melody
  melody_last  in  IDX_W  index of the last note played
  wr_en  in  1  melody RAM write strobe
  wr_addr  in  IDX_W  write address
  wr_data  in  AUD_W+2  {dur[1:0], inc[AUD_W-1:0]}
  fm_out  out  1  carrier accumulator MSB
  audio_out  out  1  audio accumulator MSB
  playing  out  1  high in PLAY
  melody_end  out  1  one-cycle end pulse
  note_index  out  IDX_W  current index
  phase_inc_out  out  ACC_W  current carrier increment
REQ-003 The block SHALL use one clock, clk. Reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 The melody RAM SHALL be 2**IDX_W x (AUD_W+2) flops. A write SHALL occur on any clk edge with wr_en=1, in any state.
REQ-005 The FSM SHALL have states IDLE, PLAY and DONE.
  - IDLE->PLAY on enable=1.
  - PLAY->IDLE on enable=0, in the same cycle, at any point.
  - DONE->IDLE on enable=0.
REQ-006 On entry to PLAY and at each note advance, the block SHALL latch cur_inc and cur_dur from RAM[note_index]. A write to that address in the same cycle SHALL NOT be seen until the next fetch.
REQ-007 Each note SHALL last (cur_dur+1)*TICKS_PER_STEP cycles, counted by a step tick counter and a step counter.
REQ-008 At note completion with note_index != melody_last, note_index SHALL increment by 1.
REQ-009 At note completion with note_index == melody_last:
  - melody_end SHALL pulse for exactly 1 cycle.
  - If loop=1, note_index SHALL go to 0 and the FSM SHALL stay in PLAY.
  - Otherwise the FSM SHALL go to DONE.
  - loop SHALL be sampled only at this cycle.
REQ-010 If melody_last is below note_index, note_index SHALL wrap modulo 2**IDX_W until it equals melody_last.
REQ-011 In PLAY, the audio accumulator SHALL add cur_inc, zero-extended to ACC_W, every cycle. cur_inc=0 SHALL be a rest: the accumulator holds and audio_out holds.
REQ-012 Carrier increment in PLAY SHALL be:
  - CARRIER_INC+DEV_INC when audio_out=1 and not a rest;
  - CARRIER_INC-DEV_INC when audio_out=0 and not a rest;
  - CARRIER_INC during a rest.
  All arithmetic SHALL be modulo 2**ACC_W.
REQ-013 phase_inc_out SHALL equal the increment applied that cycle. It SHALL be 0 outside PLAY.
REQ-014 In IDLE and DONE:
  - both accumulators SHALL be cleared;
  - fm_out, audio_out, playing and melody_end SHALL be 0;
  - all counters SHALL be cleared;
  - note_index SHALL be 0 in IDLE and hold its last value in DONE.

Reset
REQ-015 While rst_n=0:
  - the state SHALL be IDLE;
  - all counters, accumulators and outputs SHALL be 0;
  - RAM contents SHALL be 0, i.e. all rests of duration 1.
REQ-016 Deassertion SHALL take effect on the next clk edge. A mid-play reset SHALL abort with no melody_end pulse.

Structure
REQ-017 Package tone_fm_pkg SHALL hold:
  - the state enum;
  - the RAM entry field widths and positions;
  - a default-melody localparam (C-major scale increments at 50 MHz).
REQ-018 A sub-module tone_nco SHALL implement the accumulator with clear, enable, increment and MSB output. It SHALL be instantiated twice, once for audio and once for the carrier.

Verification (bench: TICKS_PER_STEP=4, IDX_W=2, ACC_W=16, AUD_W=8, CARRIER_INC=16'h1000, DEV_INC=16'h0100)
REQ-019 Reset: assert rst_n=0 mid-PLAY -> all outputs 0 within the same cycle, no melody_end. After release with enable=1 -> playing=1 one edge later.
REQ-020 Sequencing: load RAM = {0:8'h40/d0, 1:8'h20/d1, 2:0/d0, 3:8'h10/d3}, melody_last=3, loop=0 -> note_index dwell 4, 8, 4, 16 cycles; melody_end is 1 cycle; then DONE with playing=0.
REQ-021 Loop: same load with loop=1 -> after index 3, note_index=0 in the next cycle, playing stays 1, one melody_end per pass.
REQ-022 FM: during note 0, phase_inc_out=16'h1100 while audio_out=1 and 16'h0F00 while it is 0. During rest note 2 -> 16'h1000 and audio_out held.
REQ-023 Abort and write: drop enable mid-note -> IDLE in the next cycle. Write addr 1 while note 1 plays -> the new value is heard only on the next pass.
REQ-024 Wrap: melody_last=1 while note_index=2 -> the sequence 2, 3, 0, 1, then melody_end.

Source files
------------

// File: rtl/tone_fm_pkg.sv
// Shared types and constants for the FM tone sequencer: FSM states,
// melody RAM entry layout and a default C-major scale.
package tone_fm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A RAM entry is {dur, inc}; the increment sits in the low bits.
  localparam int DUR_W   = 2;
  localparam int INC_LSB = 0;

  function automatic int dur_lsb(input int aud_w);
    return INC_LSB + aud_w;
  endfunction

  // C4..C5 audio increments for a 32-bit accumulator clocked at 50 MHz.
  localparam int DEFAULT_LEN = 8;
  localparam logic [DEFAULT_LEN-1:0][15:0] DEFAULT_MELODY = {
    16'd44947,  // C5
    16'd42424,  // B4
    16'd37796,  // A4
    16'd33673,  // G4
    16'd29999,  // F4
    16'd28315,  // E4
    16'd25225,  // D4
    16'd22474   // C4
  };

endpackage

// File: rtl/tone_nco.sv
// Phase accumulator with synchronous clear and enable; the MSB is the
// square-wave output.
module tone_nco #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] inc,
  output logic         msb
);

  logic [W-1:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + inc;
    end
  end

  assign msb = acc[W-1];

endmodule

// File: rtl/tone_fm_seq_tx.sv
// Melody sequencer: steps through a small note RAM and frequency-modulates
// a carrier NCO with the square wave of an audio NCO.
module tone_fm_seq_tx
  import tone_fm_pkg::*;
#(
  parameter int               IDX_W          = 4,
  parameter int               AUD_W          = 16,
  parameter int               ACC_W          = 32,
  parameter int               TICKS_PER_STEP = 6_250_000,
  parameter logic [ACC_W-1:0] CARRIER_INC    = 32'h0CCC_CCCD,
  parameter logic [ACC_W-1:0] DEV_INC        = 32'h0000_4000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               loop,
  input  logic [IDX_W-1:0]   melody_last,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [AUD_W+1:0]   wr_data,
  output logic               fm_out,
  output logic               audio_out,
  output logic               playing,
  output logic               melody_end,
  output logic [IDX_W-1:0]   note_index,
  output logic [ACC_W-1:0]   phase_inc_out
);

  localparam int DEPTH   = 2**IDX_W;
  localparam int ENT_W   = AUD_W + DUR_W;
  localparam int DUR_POS = dur_lsb(AUD_W);
  localparam int TICK_W  = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

  state_t             state, state_nxt;
  logic [ENT_W-1:0]   ram [DEPTH];
  logic [AUD_W-1:0]   cur_inc;
  logic [DUR_W-1:0]   cur_dur;
  logic [TICK_W-1:0]  tick_cnt;
  logic [DUR_W-1:0]   step_cnt;
  logic               tick_last, note_done, at_last, rest;
  logic               fetch;
  logic [IDX_W-1:0]   fetch_idx;
  logic               nco_clr, nco_en;
  logic               audio_msb, carrier_msb;
  logic [ACC_W-1:0]   aud_inc, car_inc;

  assign tick_last = (tick_cnt == TICK_W'(TICKS_PER_STEP - 1));
  assign note_done = tick_last && (step_cnt == cur_dur);
  assign at_last   = (note_index == melody_last);
  assign rest      = (cur_inc == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram[i] <= '0;
      end
    end else if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dropping enable wins over note completion, so an abort never pulses melody_end.
  always_comb begin
    state_nxt  = state;
    playing    = 1'b0;
    melody_end = 1'b0;
    fetch      = 1'b0;
    fetch_idx  = note_index;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = ST_PLAY;
          fetch     = 1'b1;
          fetch_idx = '0;
        end
      end
      ST_PLAY: begin
        playing = 1'b1;
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (note_done) begin
          fetch = 1'b1;
          if (!at_last) begin
            fetch_idx = note_index + IDX_W'(1);
          end else begin
            melody_end = 1'b1;
            fetch_idx  = '0;
            if (!loop) begin
              state_nxt = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // The fetch reads the RAM before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_index <= '0;
      cur_inc    <= '0;
      cur_dur    <= '0;
      tick_cnt   <= '0;
      step_cnt   <= '0;
    end else if (state_nxt != ST_PLAY) begin
      cur_inc  <= '0;
      cur_dur  <= '0;
      tick_cnt <= '0;
      step_cnt <= '0;
      if (state_nxt == ST_IDLE) begin
        note_index <= '0;
      end
    end else if (fetch) begin
      note_index <= fetch_idx;
      cur_inc    <= ram[fetch_idx][INC_LSB +: AUD_W];
      cur_dur    <= ram[fetch_idx][DUR_POS +: DUR_W];
      tick_cnt   <= '0;
      step_cnt   <= '0;
    end else begin
      tick_cnt <= tick_last ? '0 : tick_cnt + TICK_W'(1);
      if (tick_last) begin
        step_cnt <= step_cnt + DUR_W'(1);
      end
    end
  end

  always_comb begin
    car_inc = '0;
    if (state == ST_PLAY) begin
      if (rest) begin
        car_inc = CARRIER_INC;
      end else if (audio_msb) begin
        car_inc = CARRIER_INC + DEV_INC;
      end else begin
        car_inc = CARRIER_INC - DEV_INC;
      end
    end
  end

  // Clearing on the way out of PLAY keeps both MSBs low in IDLE and DONE.
  assign nco_clr = (state_nxt != ST_PLAY);
  assign nco_en  = (state == ST_PLAY);
  assign aud_inc = {{(ACC_W-AUD_W){1'b0}}, cur_inc};

  tone_nco #(.W(ACC_W)) u_audio_nco (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (nco_clr),
    .en    (nco_en),
    .inc   (aud_inc),
    .msb   (audio_msb)
  );

  tone_nco #(.W(ACC_W)) u_carrier_nco (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (nco_clr),
    .en    (nco_en),
    .inc   (car_inc),
    .msb   (carrier_msb)
  );

  assign audio_out     = audio_msb;
  assign fm_out        = carrier_msb;
  assign phase_inc_out = car_inc;

endmodule

// File: tb/tb_tone_fm_seq_tx.sv
// Self-checking bench for tone_fm_seq_tx: directed scenarios plus random
// play, all compared cycle by cycle against a note-level reference model.
module tb_tone_fm_seq_tx;

  localparam int S_IDLE = 0;
  localparam int S_PLAY = 1;
  localparam int S_DONE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        loop;
  logic [1:0]  melody_last;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [9:0]  wr_data;
  logic        fm_out;
  logic        audio_out;
  logic        playing;
  logic        melody_end;
  logic [1:0]  note_index;
  logic [15:0] phase_inc_out;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          m_state;
  logic [1:0]  m_idx;
  logic [7:0]  m_inc;
  int          m_left;
  logic [15:0] m_aud;
  logic [15:0] m_car;
  logic [9:0]  mem [4];

  logic        trace_on = 1'b0;
  int          trace[$];
  int          end_pulses;
  int          run_idx[$];
  int          run_len[$];

  tone_fm_seq_tx #(
    .IDX_W          (2),
    .AUD_W          (8),
    .ACC_W          (16),
    .TICKS_PER_STEP (4),
    .CARRIER_INC    (16'h1000),
    .DEV_INC        (16'h0100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .loop          (loop),
    .melody_last   (melody_last),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .fm_out        (fm_out),
    .audio_out     (audio_out),
    .playing       (playing),
    .melody_end    (melody_end),
    .note_index    (note_index),
    .phase_inc_out (phase_inc_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic lp, input logic [1:0] last);
    enable      = en;
    loop        = lp;
    melody_last = last;
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_idx   = '0;
    m_inc   = '0;
    m_left  = 0;
    m_aud   = '0;
    m_car   = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
  endtask

  task automatic load_note();
    m_inc  = mem[m_idx][7:0];
    m_left = (int'(mem[m_idx][9:8]) + 1) * 4;
  endtask

  function automatic logic [15:0] exp_pinc();
    if (m_state != S_PLAY) return 16'h0000;
    if (m_inc == 8'h00) return 16'h1000;
    return m_aud[15] ? 16'h1100 : 16'h0F00;
  endfunction

  function automatic logic exp_end();
    return (m_state == S_PLAY) && enable && (m_left == 1) && (m_idx == melody_last);
  endfunction

  task automatic model_update();
    logic [15:0] pinc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pinc = exp_pinc();
    case (m_state)
      S_IDLE: if (enable) begin
        m_state = S_PLAY;
        m_idx   = '0;
        load_note();
      end
      S_PLAY: if (!enable) begin
        m_state = S_IDLE;
        m_idx   = '0;
        m_aud   = '0;
        m_car   = '0;
      end else begin
        m_aud = m_aud + {8'h00, m_inc};
        m_car = m_car + pinc;
        if (m_left == 1) begin
          if (m_idx != melody_last) begin
            m_idx = m_idx + 2'd1;
            load_note();
          end else if (loop) begin
            m_idx = '0;
            load_note();
          end else begin
            m_state = S_DONE;
            m_aud   = '0;
            m_car   = '0;
          end
        end else begin
          m_left--;
        end
      end
      default: if (!enable) begin
        m_state = S_IDLE;
        m_idx   = '0;
      end
    endcase
    if (wr_en) mem[wr_addr] = wr_data;
  endtask

  task automatic step_cycle();
    #1;
    checkOutput("playing",    playing,       (m_state == S_PLAY));
    checkOutput("audio_out",  audio_out,     m_aud[15]);
    checkOutput("fm_out",     fm_out,        m_car[15]);
    checkOutput("melody_end", melody_end,    exp_end());
    checkOutput("note_index", note_index,    m_idx);
    checkOutput("phase_inc",  phase_inc_out, exp_pinc());
    if (trace_on) begin
      if (playing) trace.push_back(int'(note_index));
      if (melody_end) end_pulses++;
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic write_word(input logic [1:0] addr, input logic [9:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    step_cycle();
    wr_en   = 1'b0;
  endtask

  task automatic load_spec_melody();
    write_word(2'd0, 10'h040);
    write_word(2'd1, 10'h120);
    write_word(2'd2, 10'h000);
    write_word(2'd3, 10'h310);
  endtask

  task automatic start_trace();
    trace.delete();
    end_pulses = 0;
    trace_on   = 1'b1;
  endtask

  task automatic analyze_trace();
    trace_on = 1'b0;
    run_idx.delete();
    run_len.delete();
    foreach (trace[i]) begin
      if (run_idx.size() == 0 || run_idx[run_idx.size()-1] != trace[i]) begin
        run_idx.push_back(trace[i]);
        run_len.push_back(1);
      end else begin
        run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
      end
    end
  endtask

  function automatic int run_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int exp_len [4];
    int exp_wrap [4];
    exp_len  = '{4, 8, 4, 16};
    exp_wrap = '{2, 3, 0, 1};

    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    applyStimulus(1'b0, 1'b0, 2'd3);
    model_reset();
    @(negedge clk);
    repeat (3) step_cycle();
    rst_n = 1'b1;
    repeat (2) step_cycle();

    // plain sequencing with no loop: dwell 4, 8, 4, 16 then DONE
    $display("[TB] sequencing");
    load_spec_melody();
    start_trace();
    applyStimulus(1'b1, 1'b0, 2'd3);
    repeat (40) step_cycle();
    analyze_trace();
    checkOutput("seq_runs", run_idx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("seq_idx%0d", i), run_at(run_idx, i), i);
      checkOutput($sformatf("seq_len%0d", i), run_at(run_len, i), exp_len[i]);
    end
    checkOutput("seq_end_pulses", end_pulses, 1);
    checkOutput("seq_done_playing", playing, 1'b0);
    checkOutput("seq_done_index", note_index, 2'd3);
    applyStimulus(1'b0, 1'b0, 2'd3);
    repeat (2) step_cycle();

    // looping: two full passes, then rewrite note 1 while it plays
    $display("[TB] loop and rewrite");
    start_trace();
    applyStimulus(1'b1, 1'b1, 2'd3);
    repeat (70) step_cycle();
    analyze_trace();
    checkOutput("loop_len", trace.size(), 69);
    checkOutput("loop_last_of_pass", run_at(trace, 31), 3);
    checkOutput("loop_wrap_to_0", run_at(trace, 32), 0);
    checkOutput("loop_end_pulses", end_pulses, 2);
    write_word(2'd1, 10'h0FF);
    repeat (40) step_cycle();
    applyStimulus(1'b0, 1'b1, 2'd3);
    step_cycle();
    #1;
    checkOutput("abort_idle", playing, 1'b0);
    checkOutput("abort_index", note_index, 2'd0);
    repeat (2) step_cycle();

    // asynchronous reset in the middle of a note
    $display("[TB] reset mid-play");
    applyStimulus(1'b1, 1'b1, 2'd3);
    repeat (10) step_cycle();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_playing", playing, 1'b0);
    checkOutput("rst_melody_end", melody_end, 1'b0);
    checkOutput("rst_audio", audio_out, 1'b0);
    checkOutput("rst_fm", fm_out, 1'b0);
    checkOutput("rst_index", note_index, 2'd0);
    checkOutput("rst_phase_inc", phase_inc_out, 16'h0000);
    model_reset();
    repeat (2) step_cycle();
    rst_n = 1'b1;
    step_cycle();
    #1;
    checkOutput("rst_release_play", playing, 1'b1);
    repeat (12) step_cycle();
    applyStimulus(1'b0, 1'b0, 2'd3);
    repeat (2) step_cycle();

    // melody_last lowered below the current index: index wraps round to it
    $display("[TB] index wrap");
    load_spec_melody();
    applyStimulus(1'b1, 1'b0, 2'd3);
    for (int c = 0; c < 50 && !(m_state == S_PLAY && m_idx == 2'd2); c++) step_cycle();
    checkOutput("wrap_reached_2", note_index, 2'd2);
    start_trace();
    applyStimulus(1'b1, 1'b0, 2'd1);
    repeat (60) step_cycle();
    analyze_trace();
    checkOutput("wrap_runs", run_idx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wrap_idx%0d", i), run_at(run_idx, i), exp_wrap[i]);
    end
    checkOutput("wrap_end_pulses", end_pulses, 1);
    applyStimulus(1'b0, 1'b0, 2'd3);
    repeat (2) step_cycle();

    // random play with live writes, loop changes and enable toggles
    $display("[TB] random play");
    enable = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      loop = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 79) == 0) melody_last = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        wr_en   = 1'b1;
        wr_addr = 2'($urandom_range(0, 3));
        wr_data = {2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255))};
      end else begin
        wr_en = 1'b0;
      end
      step_cycle();
    end
    wr_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd3);
    repeat (2) step_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
